rv_mem_model: RTL and testbench
===============================

# rv_mem_model

Parametrised bus-functional memory model for uRV core simulation and FPGA bring-up. It serves the instruction port and the data port of `rv_cpu` from one shared word array. Each port has an independent, reproducible pseudo-random wait-state generator. A memory-mapped console byte sink sits behind a FIFO with a valid/ready output. The block sits between `rv_cpu` and the testbench or board top and replaces ad-hoc behavioural memories.

## Interface
- `g_mem_words`, 16384: word count of the RAM (any value ≥ 2). Word index = (addr >> 2) mod `g_mem_words`.
- `g_init_file`, "": hex image loaded with `$readmemh` at elaboration; empty = no preload.
- `g_im_stall_thr`, 0: 9-bit instruction-port stall threshold, 0..256. 0 = never stall, 256 = always stall.
- `g_dm_stall_thr`, 0: 9-bit data-port stall threshold, same encoding.
- `g_lfsr_seed`, 16'hACE1: LFSR reset value; 0 is replaced by 1.
- `g_console_addr`, 32'h0010_0000: word-aligned console address.
- `g_fifo_depth`, 8: console FIFO depth, power of two, 2..256.
- `clk_i` in 1: clock; all logic on the rising edge.
- `rst_i` in 1: **one clock; reset is synchronous and active-high**.
- `im_addr_i` in 32: instruction fetch address.
- `im_data_o` out 32: fetched word.
- `im_valid_o` out 1: `im_data_o` valid this cycle.
- `dm_addr_i` in 32: data address, sampled every cycle.
- `dm_data_s_i` in 32: store data.
- `dm_data_select_i` in 4: byte-lane enables for stores.
- `dm_write_i` in 1: store strobe.
- `dm_data_l_o` out 32: load data.
- `dm_valid_l_o` out 1: `dm_data_l_o` valid this cycle.
- `con_data_o` out 8: console FIFO head byte.
- `con_valid_o` out 1: FIFO non-empty.
- `con_ready_i` in 1: sink accepts the head byte.
- `con_overflow_o` out 8: saturating count of dropped console bytes.

## Operation
- LFSR: 16-bit Galois, mask 16'hB400, shifts right every cycle outside reset.
  - `im_stall` = {1'b0, lfsr[7:0]} < `g_im_stall_thr`.
  - `dm_stall` = {1'b0, lfsr[15:8]} < `g_dm_stall_thr`.
  - Both use the pre-shift LFSR value.
- Instruction port, per cycle:
  - Not stalled: `im_data_o` <= mem[im idx], `im_valid_o` <= 1.
  - Stalled: `im_valid_o` <= 0, `im_data_o` holds.
- Data read, per cycle:
  - Not stalled: `dm_data_l_o` <= rdata, `dm_valid_l_o` <= 1. rdata = mem[dm idx], or {24'h0, FIFO level[7:0]} when `dm_addr_i` == `g_console_addr`; level saturates at 255.
  - Stalled: `dm_valid_l_o` <= 0, `dm_data_l_o` holds.
- Data write: `dm_write_i` is never stalled; it is accepted in the same cycle. Each lane n with `dm_data_select_i[n]`=1 writes byte n of mem[dm idx].
- Read and write to the same word in one cycle: the read returns the old data. The instruction port sees the same read-before-write ordering.
- Console: a write with `dm_addr_i` == `g_console_addr` does not touch the RAM.
  - It pushes `dm_data_s_i[7:0]` into the FIFO; `dm_data_select_i` is ignored.
  - Push is accepted if level < depth, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `con_overflow_o` increments, saturating at 255.
- FIFO: a pop occurs when `con_valid_o` && `con_ready_i`.
  - `con_data_o` always shows the head entry.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo depth; the level counter is log2(depth)+1 bits.
- RAM contents are not affected by reset.

## Timing
- Reset values: `im_valid_o`=0, `dm_valid_l_o`=0, `im_data_o`=0, `dm_data_l_o`=0, `con_valid_o`=0, `con_data_o`=0, `con_overflow_o`=0, FIFO empty, LFSR=seed.
- Read latency is 1 cycle for both ports: an address at edge k produces data/valid after edge k+1, provided that cycle is not stalled.
- Stores update the RAM at the edge that samples them.
- A console push is visible on `con_valid_o` one cycle later; zero-latency bypass is not allowed.
- The level seen by a status read is the pre-edge level.
- Asserting `rst_i` mid-operation:
  - Next edge: all outputs return to reset values, the FIFO empties (pending bytes discarded), and the overflow count clears.
  - Stores presented in the reset cycle are ignored.

## Test plan
- Thresholds 0, mem[4]=32'hDEADBEEF, `im_addr_i`=0x10 held → `im_data_o`=DEADBEEF and `im_valid_o`=1 from the first cycle after reset release, with no gaps over 100 cycles.
- mem[8]=32'h11223344, store 0x20 ← 32'hAABBCCDD with select 4'b0101, then load 0x20 → 32'h11BB33DD. A load of 0x20 in the store cycle itself → 32'h11223344.
- `con_ready_i`=0, store 0x48 then 0x69 to 0x100000 → status load returns 2 and RAM word (0x40000 mod `g_mem_words`) is unchanged. Then `con_ready_i`=1 → `con_data_o` shows 0x48 then 0x69 on consecutive cycles, and `con_valid_o` drops after.
- Depth 8, 10 console stores with ready low → level 8, `con_overflow_o`=2. An 11th store with ready high in the same cycle → accepted, level stays 8, overflow stays 2.
- Thresholds 128/64, seed 16'hACE1, 4096 cycles → `im_valid_o`/`dm_valid_l_o` match a cycle-exact software LFSR model. Threshold 256 → valid never asserted.
- With FIFO level 3 and overflow 1, assert `rst_i` for 1 cycle → next cycle level 0, overflow 0, valids 0, LFSR=seed; a preloaded word reads back intact.

Source files
------------

// File: rtl/rv_mem_model_if.sv
// Bus bundle between rv_cpu (master) and the memory model (slave):
// instruction port, data port and console byte sink.
interface rv_mem_model_if;
  logic [31:0] im_addr_i;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_write_i;
  logic [31:0] dm_data_l_o;
  logic        dm_valid_l_o;
  logic [7:0]  con_data_o;
  logic        con_valid_o;
  logic        con_ready_i;
  logic [7:0]  con_overflow_o;

  modport master (
    output im_addr_i, dm_addr_i, dm_data_s_i, dm_data_select_i, dm_write_i, con_ready_i,
    input  im_data_o, im_valid_o, dm_data_l_o, dm_valid_l_o, con_data_o, con_valid_o,
           con_overflow_o
  );
  modport slave (
    input  im_addr_i, dm_addr_i, dm_data_s_i, dm_data_select_i, dm_write_i, con_ready_i,
    output im_data_o, im_valid_o, dm_data_l_o, dm_valid_l_o, con_data_o, con_valid_o,
           con_overflow_o
  );
endinterface

// File: rtl/rv_mem_model.sv
// Shared instruction/data word memory with LFSR-driven wait states and a
// memory-mapped console byte FIFO.
module rv_mem_model #(
  parameter int unsigned g_mem_words    = 16384,
  parameter string       g_init_file    = "",
  parameter logic [8:0]  g_im_stall_thr = 9'd0,
  parameter logic [8:0]  g_dm_stall_thr = 9'd0,
  parameter logic [15:0] g_lfsr_seed    = 16'hACE1,
  parameter logic [31:0] g_console_addr = 32'h0010_0000,
  parameter int unsigned g_fifo_depth   = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  rv_mem_model_if.slave bus
);
  localparam int unsigned IW = (g_mem_words > 1) ? $clog2(g_mem_words) : 1;
  localparam int unsigned FW = $clog2(g_fifo_depth);
  localparam logic [FW:0] DEPTH = (FW+1)'(g_fifo_depth);
  localparam logic [15:0] SEED = (g_lfsr_seed == 16'h0) ? 16'h0001 : g_lfsr_seed;

  logic [31:0] mem [g_mem_words];

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) % g_mem_words;
    return w[IW-1:0];
  endfunction

  logic [15:0]   lfsr;
  logic          im_stall, dm_stall;
  logic [IW-1:0] im_idx, dm_idx;
  logic          is_con, con_wr, ram_wr, pop, push;
  logic [7:0]    fifo [g_fifo_depth];
  logic [FW-1:0] rd_ptr, wr_ptr;
  logic [FW:0]   level;
  logic [8:0]    level9;
  logic [7:0]    level8;
  logic [31:0]   rdata;
  logic [31:0]   im_data, dm_data;
  logic          im_valid, dm_valid;
  logic [7:0]    overflow;

  // Stall decisions use the LFSR value before this cycle's shift.
  assign im_stall = {1'b0, lfsr[7:0]}  < g_im_stall_thr;
  assign dm_stall = {1'b0, lfsr[15:8]} < g_dm_stall_thr;

  assign im_idx = word_idx(bus.im_addr_i);
  assign dm_idx = word_idx(bus.dm_addr_i);
  assign is_con = (bus.dm_addr_i == g_console_addr);
  assign con_wr = bus.dm_write_i && is_con;
  assign ram_wr = bus.dm_write_i && !is_con;

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign pop    = (level != '0) && bus.con_ready_i;
  assign push   = con_wr && ((level != DEPTH) || pop);

  assign level9 = 9'(level);
  assign level8 = level9[8] ? 8'hFF : level9[7:0];
  assign rdata  = is_con ? {24'h0, level8} : mem[dm_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= SEED;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // RAM has no reset; stores in a reset cycle are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && ram_wr) begin
      for (int n = 0; n < 4; n++)
        if (bus.dm_data_select_i[n]) mem[dm_idx][8*n +: 8] <= bus.dm_data_s_i[8*n +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      im_data  <= '0;
      im_valid <= 1'b0;
      dm_data  <= '0;
      dm_valid <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= '0;
      for (int i = 0; i < int'(g_fifo_depth); i++) fifo[i] <= '0;
    end else begin
      im_valid <= !im_stall;
      if (!im_stall) im_data <= mem[im_idx];
      dm_valid <= !dm_stall;
      if (!dm_stall) dm_data <= rdata;

      if (push) begin
        fifo[wr_ptr] <= bus.dm_data_s_i[7:0];
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;

      if (con_wr && !push && (overflow != 8'hFF)) overflow <= overflow + 8'd1;
    end
  end

  assign bus.im_data_o      = im_data;
  assign bus.im_valid_o     = im_valid;
  assign bus.dm_data_l_o    = dm_data;
  assign bus.dm_valid_l_o   = dm_valid;
  assign bus.con_data_o     = fifo[rd_ptr];
  assign bus.con_valid_o    = (level != '0);
  assign bus.con_overflow_o = overflow;
endmodule

// File: tb/tb_rv_mem_model.sv
// Directed bench for rv_mem_model: three instances cover zero, random and
// permanent wait states.
module tb_rv_mem_model;
  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rv_mem_model_if if0 ();
  rv_mem_model_if if1 ();
  rv_mem_model_if if2 ();

  rv_mem_model #(.g_mem_words(64), .g_im_stall_thr(9'd0), .g_dm_stall_thr(9'd0))
    dut0 (.clk_i(clk), .rst_i(rst0), .bus(if0));
  rv_mem_model #(.g_mem_words(64), .g_im_stall_thr(9'd128), .g_dm_stall_thr(9'd64))
    dut1 (.clk_i(clk), .rst_i(rst1), .bus(if1));
  rv_mem_model #(.g_mem_words(64), .g_im_stall_thr(9'd256), .g_dm_stall_thr(9'd256))
    dut2 (.clk_i(clk), .rst_i(rst1), .bus(if2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst0 = 1'b1;
    tick();
    n_cmp++; if (if0.im_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_im_valid: got %b want 0", if0.im_valid_o); end
    n_cmp++; if (if0.dm_valid_l_o !== 1'b0) begin n_bad++; $display("FAIL rst_dm_valid: got %b want 0", if0.dm_valid_l_o); end
    n_cmp++; if (if0.im_data_o !== 32'h0) begin n_bad++; $display("FAIL rst_im_data: got %h want 0", if0.im_data_o); end
    n_cmp++; if (if0.dm_data_l_o !== 32'h0) begin n_bad++; $display("FAIL rst_dm_data: got %h want 0", if0.dm_data_l_o); end
    n_cmp++; if (if0.con_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_con_valid: got %b want 0", if0.con_valid_o); end
    n_cmp++; if (if0.con_data_o !== 8'h0) begin n_bad++; $display("FAIL rst_con_data: got %h want 0", if0.con_data_o); end
    n_cmp++; if (if0.con_overflow_o !== 8'h0) begin n_bad++; $display("FAIL rst_overflow: got %h want 0", if0.con_overflow_o); end
    rst0 = 1'b0;
  endtask

  task automatic test_fetch;
    // Preload mem[4] through the data port, then reset: RAM survives reset.
    if0.dm_addr_i = 32'h10; if0.dm_data_s_i = 32'hDEADBEEF; if0.dm_data_select_i = 4'hF;
    if0.dm_write_i = 1'b1;
    tick();
    if0.dm_write_i = 1'b0;
    if0.im_addr_i = 32'h10;
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_cmp++;
      if (if0.im_valid_o !== 1'b1 || if0.im_data_o !== 32'hDEADBEEF) begin
        n_bad++;
        $display("FAIL fetch_c%0d: got v=%b %h want v=1 deadbeef", i, if0.im_valid_o, if0.im_data_o);
      end
    end
  endtask

  task automatic test_byte_store;
    if0.dm_addr_i = 32'h20; if0.dm_data_s_i = 32'h11223344; if0.dm_data_select_i = 4'hF;
    if0.dm_write_i = 1'b1;
    tick();
    if0.dm_data_s_i = 32'hAABBCCDD; if0.dm_data_select_i = 4'b0101;
    tick();
    n_cmp++; if (if0.dm_data_l_o !== 32'h11223344 || if0.dm_valid_l_o !== 1'b1) begin
      n_bad++; $display("FAIL rbw_load: got v=%b %h want v=1 11223344", if0.dm_valid_l_o, if0.dm_data_l_o); end
    if0.dm_write_i = 1'b0;
    tick();
    n_cmp++; if (if0.dm_data_l_o !== 32'h11BB33DD) begin
      n_bad++; $display("FAIL byte_lanes: got %h want 11bb33dd", if0.dm_data_l_o); end
  endtask

  task automatic test_console;
    if0.dm_addr_i = 32'h0; if0.dm_data_s_i = 32'hCAFEF00D; if0.dm_data_select_i = 4'hF;
    if0.dm_write_i = 1'b1; if0.con_ready_i = 1'b0;
    tick();
    // Upper data bits and lane enables must not matter for console pushes.
    if0.dm_addr_i = 32'h0010_0000; if0.dm_data_s_i = 32'hFFFF_FF48; if0.dm_data_select_i = 4'h0;
    tick();
    n_cmp++; if (if0.con_valid_o !== 1'b1 || if0.con_data_o !== 8'h48) begin
      n_bad++; $display("FAIL con_first: got v=%b %h want v=1 48", if0.con_valid_o, if0.con_data_o); end
    if0.dm_data_s_i = 32'h0000_0069;
    tick();
    if0.dm_write_i = 1'b0;
    tick();
    n_cmp++; if (if0.dm_data_l_o !== 32'd2) begin
      n_bad++; $display("FAIL con_level2: got %h want 2", if0.dm_data_l_o); end
    if0.dm_addr_i = 32'h0;
    tick();
    n_cmp++; if (if0.dm_data_l_o !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL con_ram_untouched: got %h want cafef00d", if0.dm_data_l_o); end
    n_cmp++; if (if0.con_data_o !== 8'h48) begin
      n_bad++; $display("FAIL con_head_hold: got %h want 48", if0.con_data_o); end
    if0.con_ready_i = 1'b1;
    tick();
    n_cmp++; if (if0.con_valid_o !== 1'b1 || if0.con_data_o !== 8'h69) begin
      n_bad++; $display("FAIL con_second: got v=%b %h want v=1 69", if0.con_valid_o, if0.con_data_o); end
    tick();
    n_cmp++; if (if0.con_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL con_drained: got %b want 0", if0.con_valid_o); end
    if0.con_ready_i = 1'b0;
  endtask

  task automatic test_overflow;
    logic [7:0] exp_head [8];
    if0.dm_addr_i = 32'h0010_0000; if0.dm_write_i = 1'b1; if0.con_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if0.dm_data_s_i = 32'h10 + i;
      tick();
    end
    n_cmp++; if (if0.con_overflow_o !== 8'd2) begin
      n_bad++; $display("FAIL ovf_count: got %0d want 2", if0.con_overflow_o); end
    if0.dm_data_s_i = 32'h1A; if0.con_ready_i = 1'b1;
    tick();
    n_cmp++; if (if0.con_overflow_o !== 8'd2 || if0.con_data_o !== 8'h11) begin
      n_bad++; $display("FAIL full_push_pop: got ovf=%0d head=%h want ovf=2 head=11", if0.con_overflow_o, if0.con_data_o); end
    if0.dm_write_i = 1'b0; if0.con_ready_i = 1'b0;
    tick();
    n_cmp++; if (if0.dm_data_l_o !== 32'd8) begin
      n_bad++; $display("FAIL full_level: got %0d want 8", if0.dm_data_l_o); end
    for (int i = 0; i < 8; i++) exp_head[i] = (i < 7) ? 8'(8'h11 + i) : 8'h1A;
    if0.con_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (if0.con_data_o !== exp_head[i] || if0.con_valid_o !== 1'b1) begin
        n_bad++; $display("FAIL drain_%0d: got v=%b %h want v=1 %h", i, if0.con_valid_o, if0.con_data_o, exp_head[i]); end
      tick();
    end
    n_cmp++; if (if0.con_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL drain_empty: got %b want 0", if0.con_valid_o); end
    // Saturation: 8 fill the FIFO, the remaining 262 all overflow.
    if0.con_ready_i = 1'b0; if0.dm_write_i = 1'b1;
    for (int i = 0; i < 270; i++) tick();
    if0.dm_write_i = 1'b0;
    n_cmp++; if (if0.con_overflow_o !== 8'hFF) begin
      n_bad++; $display("FAIL ovf_saturate: got %h want ff", if0.con_overflow_o); end
  endtask

  task automatic test_reset_mid;
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    if0.dm_addr_i = 32'h0010_0000; if0.dm_write_i = 1'b1; if0.con_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if0.dm_data_s_i = 32'h30 + i;
      tick();
    end
    if0.dm_write_i = 1'b0; if0.con_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    if0.con_ready_i = 1'b0;
    tick();
    n_cmp++; if (if0.dm_data_l_o !== 32'd3 || if0.con_overflow_o !== 8'd1 || if0.con_data_o !== 8'h35) begin
      n_bad++; $display("FAIL pre_reset: got lvl=%0d ovf=%0d head=%h want 3 1 35", if0.dm_data_l_o, if0.con_overflow_o, if0.con_data_o); end
    // Store in the reset cycle must be ignored.
    rst0 = 1'b1;
    if0.dm_addr_i = 32'h10; if0.dm_data_s_i = 32'h0BADBAD0; if0.dm_data_select_i = 4'hF;
    if0.dm_write_i = 1'b1;
    tick();
    rst0 = 1'b0; if0.dm_write_i = 1'b0;
    n_cmp++; if (if0.con_valid_o !== 1'b0 || if0.con_data_o !== 8'h0 || if0.con_overflow_o !== 8'h0) begin
      n_bad++; $display("FAIL mid_rst_con: got v=%b d=%h ovf=%h want 0 0 0", if0.con_valid_o, if0.con_data_o, if0.con_overflow_o); end
    n_cmp++; if (if0.im_valid_o !== 1'b0 || if0.dm_valid_l_o !== 1'b0 || if0.im_data_o !== 32'h0 || if0.dm_data_l_o !== 32'h0) begin
      n_bad++; $display("FAIL mid_rst_ports: got iv=%b dv=%b id=%h dd=%h want all 0", if0.im_valid_o, if0.dm_valid_l_o, if0.im_data_o, if0.dm_data_l_o); end
    if0.dm_addr_i = 32'h0010_0000; if0.im_addr_i = 32'h10;
    tick();
    n_cmp++; if (if0.dm_data_l_o !== 32'd0 || if0.dm_valid_l_o !== 1'b1) begin
      n_bad++; $display("FAIL mid_rst_level: got v=%b %0d want v=1 0", if0.dm_valid_l_o, if0.dm_data_l_o); end
    n_cmp++; if (if0.im_data_o !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL mid_rst_ram: got %h want deadbeef", if0.im_data_o); end
  endtask

  task automatic test_lfsr_stall;
    logic [15:0] m;
    logic        exp_im, exp_dm;
    for (int pass = 0; pass < 2; pass++) begin
      rst1 = 1'b1;
      tick();
      n_cmp++; if (if1.im_valid_o !== 1'b0 || if1.dm_valid_l_o !== 1'b0) begin
        n_bad++; $display("FAIL lfsr_rst_p%0d: got %b%b want 00", pass, if1.im_valid_o, if1.dm_valid_l_o); end
      rst1 = 1'b0;
      m = 16'hACE1;
      for (int c = 0; c < ((pass == 0) ? 4096 : 64); c++) begin
        tick();
        exp_im = !({1'b0, m[7:0]}  < 9'd128);
        exp_dm = !({1'b0, m[15:8]} < 9'd64);
        n_cmp++; if (if1.im_valid_o !== exp_im || if1.dm_valid_l_o !== exp_dm) begin
          n_bad++; $display("FAIL lfsr_p%0d_c%0d: got %b%b want %b%b", pass, c, if1.im_valid_o, if1.dm_valid_l_o, exp_im, exp_dm); end
        n_cmp++; if (if2.im_valid_o !== 1'b0 || if2.dm_valid_l_o !== 1'b0) begin
          n_bad++; $display("FAIL always_stall_p%0d_c%0d: got %b%b want 00", pass, c, if2.im_valid_o, if2.dm_valid_l_o); end
        m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
      end
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    if0.im_addr_i = '0; if0.dm_addr_i = '0; if0.dm_data_s_i = '0; if0.dm_data_select_i = '0;
    if0.dm_write_i = 1'b0; if0.con_ready_i = 1'b0;
    if1.im_addr_i = '0; if1.dm_addr_i = '0; if1.dm_data_s_i = '0; if1.dm_data_select_i = '0;
    if1.dm_write_i = 1'b0; if1.con_ready_i = 1'b0;
    if2.im_addr_i = '0; if2.dm_addr_i = '0; if2.dm_data_s_i = '0; if2.dm_data_select_i = '0;
    if2.dm_write_i = 1'b0; if2.con_ready_i = 1'b0;
    test_reset();
    test_fetch();
    test_byte_store();
    test_console();
    test_overflow();
    test_reset_mid();
    test_lfsr_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
